imgproc_msg_reader: RTL and testbench

Avalon-MM master that drains the image processor's bounding-box message FIFO through its slave port. It polls the status register, pops message words, checks the tag sequence, and assembles complete 8-word sets (x/y extents for white, red, blue, yellow). Validated sets are published to local logic (motor/navigation control) through a registered lookup port and presence flags, so the CPU is not needed in the vision-to-control path.

---
 rtl/imgproc_msg_reader.sv | 182 ++++++++++++++++++
 tb/tb_imgproc_msg_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imgproc_msg_reader.sv
// imgproc_msg_reader: Avalon-MM master that polls the image processor's message FIFO and publishes validated 8-word box sets.
// Optional feature: define IMGPROC_MSG_READER_FLUSH_EN to flush the slave FIFO (write 0x10 to address 0) after a sequence error.
module imgproc_msg_reader #(
    parameter int POLL_INTERVAL = 1024,
    parameter int MAX_DRAIN     = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        m_chipselect,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic [2:0]  rd_idx,
    output logic [21:0] rd_data,
    output logic [3:0]  obj_present,
    output logic        set_valid,
    output logic [7:0]  err_count,
    output logic        busy
);

    localparam int CW = $clog2(POLL_INTERVAL);

    typedef enum logic [2:0] {
        IDLE,
        STAT_RD,
        STAT_WAIT,
        MSG_RD,
        MSG_WAIT
`ifdef IMGPROC_MSG_READER_FLUSH_EN
        , FLUSH_WR
`endif
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    poll_cnt;
    logic [7:0]       remaining;
    logic [2:0]       exp_tag;
    logic [7:0][21:0] shadow;
    logic [7:0][21:0] committed;

    logic [4:0]       msg_tag;
    logic [21:0]      msg_box;
    logic             tag_match;
    logic [7:0]       drain_count;
    logic [7:0][21:0] next_set;
    logic [3:0]       next_present;
    logic             unused_status_bits;

    // Status bits [7:0] carry nothing this reader needs.
    assign unused_status_bits = ^m_readdata[7:0];

    assign msg_tag   = m_readdata[31:27];
    assign msg_box   = {m_readdata[26:16], m_readdata[10:0]};
    assign tag_match = (msg_tag == {2'b00, exp_tag});
    assign drain_count = (int'(m_readdata[15:8]) > MAX_DRAIN) ? 8'(MAX_DRAIN) : m_readdata[15:8];
    assign busy      = (state != IDLE);

    // The set as it will look once the tag-7 word lands, so presence flags update with the commit.
    always_comb begin
        next_set    = shadow;
        next_set[7] = msg_box;
        for (int c = 0; c < 4; c++) begin
            next_present[c] = (next_set[2*c][21:11]   <= next_set[2*c][10:0]) &&
                              (next_set[2*c+1][21:11] <= next_set[2*c+1][10:0]);
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        m_chipselect = 1'b0;
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_address    = 3'd0;
        m_writedata  = 32'd0;
        case (state)
            IDLE: begin
                if (poll_cnt == '0) state_next = STAT_RD;
            end
            STAT_RD: begin
                m_chipselect = 1'b1;
                m_read       = 1'b1;
                state_next   = STAT_WAIT;
            end
            STAT_WAIT: begin
                state_next = (drain_count == 8'd0) ? IDLE : MSG_RD;
            end
            MSG_RD: begin
                m_chipselect = 1'b1;
                m_read       = 1'b1;
                m_address    = 3'd1;
                state_next   = MSG_WAIT;
            end
            MSG_WAIT: begin
                state_next = (remaining > 8'd1) ? MSG_RD : IDLE;
`ifdef IMGPROC_MSG_READER_FLUSH_EN
                if (!tag_match) state_next = FLUSH_WR;
`endif
            end
`ifdef IMGPROC_MSG_READER_FLUSH_EN
            FLUSH_WR: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_writedata  = 32'h10;
                state_next   = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // NOTE: shadow/committed are small flop arrays and are reset, because the committed set is readable straight after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            poll_cnt    <= CW'(POLL_INTERVAL - 1);
            remaining   <= 8'd0;
            exp_tag     <= 3'd0;
            shadow      <= '0;
            committed   <= '0;
            rd_data     <= 22'd0;
            obj_present <= 4'd0;
            set_valid   <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            set_valid <= 1'b0;
            rd_data   <= committed[rd_idx];

            // Reload while busy so IDLE always lasts POLL_INTERVAL cycles.
            if (state != IDLE) begin
                poll_cnt <= CW'(POLL_INTERVAL - 1);
            end else if (poll_cnt != '0) begin
                poll_cnt <= poll_cnt - 1'b1;
            end

            case (state)
                STAT_WAIT: remaining <= drain_count;
                MSG_WAIT: begin
                    remaining <= remaining - 8'd1;
                    if (tag_match) begin
                        shadow[exp_tag] <= msg_box;
                        if (exp_tag == 3'd7) begin
                            committed   <= next_set;
                            obj_present <= next_present;
                            set_valid   <= 1'b1;
                            exp_tag     <= 3'd0;
                        end else begin
                            exp_tag <= exp_tag + 3'd1;
                        end
                    end else begin
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        // A stray tag 0 is a fresh start; anything else abandons the partial set.
                        if (msg_tag == 5'd0) begin
                            shadow[0] <= msg_box;
                            exp_tag   <= 3'd1;
                        end else begin
                            exp_tag <= 3'd0;
                        end
                    end
                end
`ifdef IMGPROC_MSG_READER_FLUSH_EN
                FLUSH_WR: begin
                    remaining <= 8'd0;
                    exp_tag   <= 3'd0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// tb_imgproc_msg_reader: random message traffic through a modelled Avalon slave FIFO,
// checked every cycle against a transaction-level model of polling, draining and set assembly.
`timescale 1ns/1ps
module tb_imgproc_msg_reader;
    localparam int N  = 16;
    localparam int MD = 10;
`ifdef IMGPROC_MSG_READER_FLUSH_EN
    localparam bit FLUSH_MODE = 1'b1;
`else
    localparam bit FLUSH_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m_chipselect, m_read, m_write;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = 32'd0;
    logic [2:0]  rd_idx = 3'd0;
    logic [21:0] rd_data;
    logic [3:0]  obj_present;
    logic        set_valid;
    logic [7:0]  err_count;
    logic        busy;

    always #5 clk = ~clk;

    imgproc_msg_reader #(.POLL_INTERVAL(N), .MAX_DRAIN(MD)) dut (
        .clk(clk), .reset_n(reset_n),
        .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
        .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .rd_idx(rd_idx), .rd_data(rd_data), .obj_present(obj_present),
        .set_valid(set_valid), .err_count(err_count), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Slave FIFO contents and reference model of the reader.
    logic [31:0] fifo[$];
    logic [21:0] m_shadow [8];
    logic [21:0] m_comm [8];
    int          m_exp = 0;
    int          m_err = 0;
    logic [3:0]  m_present = 4'd0;
    int          sv_seen = 0;

    task automatic model_apply(input logic [31:0] w, output bit commit, output bit error);
        int tag;
        logic [21:0] box;
        tag = int'(w[31:27]);
        box = {w[26:16], w[10:0]};
        commit = 1'b0;
        error  = 1'b0;
        if (tag == m_exp) begin
            m_shadow[tag] = box;
            if (tag == 7) begin
                m_comm = m_shadow;
                for (int c = 0; c < 4; c++) begin
                    int xmin, xmax, ymin, ymax;
                    xmin = int'(m_comm[2*c][21:11]);   xmax = int'(m_comm[2*c][10:0]);
                    ymin = int'(m_comm[2*c+1][21:11]); ymax = int'(m_comm[2*c+1][10:0]);
                    m_present[c] = (xmin <= xmax) && (ymin <= ymax);
                end
                commit = 1'b1;
                m_exp  = 0;
            end else begin
                m_exp = m_exp + 1;
            end
        end else begin
            error = 1'b1;
            if (m_err < 255) m_err = m_err + 1;
            if (tag == 0) begin
                m_shadow[0] = box;
                m_exp = 1;
            end else begin
                m_exp = 0;
            end
        end
    endtask

    // Per-cycle bus slave, schedule model and output comparison.
    longint      cyc = 0;
    longint      next_stat = 0, next_msg = 0, busy_start = 0, busy_end = -1, flush_at = -1;
    int          msg_left = 0;
    int          cnt, d;
    bit          prev_rst_low = 1'b1;
    bit          pend1_v = 1'b0, pend2_v = 1'b0;
    logic [31:0] pend1 = 32'd0, pend2 = 32'd0, next_rdata = 32'd0;
    logic [21:0] exp_rd = 22'd0, saved_rd = 22'd0;
    bit          prev_strobe = 1'b0;
    bit          commit, error, e_rd, e_wr;
    logic [2:0]  e_addr;

    initial begin : bus_proc
        forever begin
            @(negedge clk);
            cyc++;
            commit = 1'b0;
            error  = 1'b0;
            if (prev_rst_low) begin
                for (int i = 0; i < 8; i++) begin
                    m_shadow[i] = 22'd0;
                    m_comm[i]   = 22'd0;
                end
                m_exp = 0; m_err = 0; m_present = 4'd0;
                pend1_v = 1'b0; pend2_v = 1'b0;
                msg_left = 0; busy_end = -1; flush_at = -1;
                next_stat = cyc + N;
                exp_rd = 22'd0;
            end else begin
                if (pend2_v) model_apply(pend2, commit, error);
                if (error && FLUSH_MODE) begin
                    msg_left  = 0;
                    flush_at  = cyc;
                    busy_end  = cyc;
                    next_stat = cyc + 1 + N;
                end
                exp_rd = saved_rd;
            end
            pend2_v = pend1_v;
            pend2   = pend1;
            pend1_v = 1'b0;

            e_rd = 1'b0;
            e_addr = 3'd0;
            if (cyc == next_stat) begin
                cnt = (fifo.size() > 255) ? 255 : fifo.size();
                d = (cnt > MD) ? MD : cnt;
                busy_start = cyc;
                busy_end   = cyc + 1 + 2 * d;
                msg_left   = d;
                next_msg   = cyc + 2;
                next_stat  = cyc + 2 + 2 * d + N;
                e_rd = 1'b1;
            end else if (msg_left > 0 && cyc == next_msg) begin
                e_rd = 1'b1;
                e_addr = 3'd1;
                msg_left--;
                next_msg = cyc + 2;
            end
            e_wr = (cyc == flush_at);

            check("chipselect", m_chipselect, e_rd | e_wr);
            check("read", m_read, e_rd);
            check("write", m_write, e_wr);
            if (e_rd || e_wr) check("address", m_address, e_addr);
            if (e_wr) check("writedata", m_writedata, 32'h10);
            if (m_chipselect) check("strobe_gap", prev_strobe, 1'b0);
            check("busy", busy, (cyc >= busy_start) && (cyc <= busy_end));
            check("set_valid", set_valid, commit);
            check("err_count", err_count, m_err);
            check("obj_present", obj_present, m_present);
            check("rd_data", rd_data, exp_rd);
            if (set_valid) sv_seen++;
            prev_strobe = m_chipselect;
            saved_rd = m_comm[rd_idx];

            // Slave behaviour: registered read data, FIFO pop, flush command.
            if (m_chipselect && m_read) begin
                if (m_address == 3'd0) begin
                    cnt = (fifo.size() > 255) ? 255 : fifo.size();
                    next_rdata = {16'($urandom), 8'(cnt), 8'($urandom)};
                end else begin
                    next_rdata = (fifo.size() > 0) ? fifo.pop_front() : 32'hFFFF_FFFF;
                    pend1_v = 1'b1;
                    pend1   = next_rdata;
                end
            end
            if (m_chipselect && m_write && m_address == 3'd0 && m_writedata == 32'h10) fifo.delete();
            prev_rst_low = !reset_n;

            @(posedge clk);
            #1 m_readdata = next_rdata;
        end
    end

    function automatic logic [31:0] box_word(input int tag, input int mn, input int mx);
        return {5'(tag), 11'(mn), 5'b0, 11'(mx)};
    endfunction

    function automatic logic [31:0] mk_word(input int tag);
        logic [10:0] mn, mx;
        if ($urandom_range(0, 4) == 0) begin
            mn = 11'd639;
            mx = 11'd0;
        end else begin
            mn = 11'($urandom_range(0, 700));
            mx = 11'($urandom_range(0, 1023));
        end
        return {5'(tag), mn, 5'($urandom), mx};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        bit seen;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_count, 8'd0);
        check("rst_present", obj_present, 4'd0);
        check("rst_set_valid", set_valid, 1'b0);
        check("rst_rd_data", rd_data, 22'd0);
        check("rst_writedata", m_writedata, 32'd0);
        @(posedge clk);
        #1;

        // Empty FIFO: bare status polls only.
        step(3 * (N + 2));

        // Set A: white x empty, all other boxes non-empty.
        fifo.push_back(box_word(0, 639, 0));
        fifo.push_back(box_word(1, 10, 20));
        fifo.push_back(box_word(2, 250, 300));
        for (int i = 3; i < 8; i++) fifo.push_back(box_word(i, 100 + i, 200 + i));
        step(2 * (N + 2) + 20);
        rd_idx = 3'd2;
        @(negedge clk);
        @(negedge clk);
        check("setA_rd2", rd_data, {11'd250, 11'd300});
        check("setA_present", obj_present, 4'b1110);
        check("setA_commits", sv_seen, 1);
        check("setA_err", err_count, 8'd0);
        @(posedge clk);
        #1;

        // Skipped tag: 0, 1, 3.
        fifo.push_back(box_word(0, 1, 2));
        fifo.push_back(box_word(1, 3, 4));
        fifo.push_back(box_word(3, 5, 6));
        step(2 * (N + 2) + 20);
        check("skip_err", err_count, 8'd1);
        check("skip_commits", sv_seen, 1);

        // Twelve words: stray 4..7 then a clean 0..7, split across two polls.
        for (int i = 4; i < 8; i++) fifo.push_back(mk_word(i));
        for (int i = 0; i < 8; i++) fifo.push_back(box_word(i, 20 * i, 20 * i + 5));
        step(3 * (N + 2) + 40);
        check("twelve_err", err_count, FLUSH_MODE ? 8'd2 : 8'd5);
        check("twelve_commits", sv_seen, FLUSH_MODE ? 1 : 2);
        rd_idx = 3'd5;
        @(negedge clk);
        @(negedge clk);
        check("twelve_rd5", rd_data, FLUSH_MODE ? {11'd105, 11'd205} : {11'd100, 11'd105});
        check("twelve_present", obj_present, FLUSH_MODE ? 4'b1110 : 4'b1111);
        @(posedge clk);
        #1;

        // Random traffic: clean sets, stray tags and idle gaps, with rd_idx wandering.
        for (int it = 0; it < 30; it++) begin
            int mode, n, wait_n;
            mode = $urandom_range(0, 3);
            if (mode <= 1) begin
                for (int t = 0; t < 8; t++) fifo.push_back(mk_word(t));
            end else if (mode == 2) begin
                n = $urandom_range(1, 12);
                for (int k = 0; k < n; k++)
                    fifo.push_back(mk_word(($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 7)));
            end
            wait_n = $urandom_range(10, 60);
            for (int w = 0; w < wait_n; w++) begin
                rd_idx = 3'($urandom);
                step(1);
            end
        end

        // Reset while a message word is in flight.
        for (int t = 0; t < 8; t++) fifo.push_back(mk_word(t));
        seen = 1'b0;
        for (int i = 0; i < 8 * (N + 2) + 200 && !seen; i++) begin
            @(negedge clk);
            if (m_chipselect && m_read && m_address == 3'd1) seen = 1'b1;
        end
        check("msg_rd_seen", seen, 1'b1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_err", err_count, 8'd0);
        check("midrst_present", obj_present, 4'd0);
        check("midrst_rd_data", rd_data, 22'd0);
        check("midrst_strobe", m_chipselect, 1'b0);
        @(posedge clk);
        #1;

        step(6 * (N + 2) + 100);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
